// File: rtl/wisc_pkg.sv
// Shared WISC-F18 constants: opcodes, condition codes, flag bit positions,
// branch FSM states and the B-target helper.
package wisc_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;

    localparam logic [2:0] CC_NE  = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GTE = 3'b100;
    localparam logic [2:0] CC_LTE = 3'b101;
    localparam logic [2:0] CC_OV  = 3'b110;
    localparam logic [2:0] CC_UNC = 3'b111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic {
        ST_IDLE,
        ST_REDIRECT
    } br_state_t;

    // Word offset becomes a byte offset; the sum wraps modulo 2^16.
    function automatic logic [15:0] b_target(input logic [15:0] pc_plus2,
                                             input logic [8:0]  imm9);
        return pc_plus2 + {{6{imm9[8]}}, imm9, 1'b0};
    endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// Bundle between the EX/ID stages, fetch, and the flag/branch unit.
// The pipeline side is master; flag_branch_unit is slave.
interface flag_branch_unit_if #(parameter int CNT_W = 16);

    logic             stall_in;
    logic             ex_valid;
    logic [3:0]       ex_opcode;
    logic [2:0]       ex_zvn;
    logic             id_valid;
    logic [3:0]       id_opcode;
    logic [2:0]       id_ccc;
    logic [8:0]       id_imm9;
    logic [15:0]      id_pc_plus2;
    logic [15:0]      id_rs_data;
    logic [2:0]       flags;
    logic             redirect_valid;
    logic [15:0]      redirect_pc;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output stall_in, ex_valid, ex_opcode, ex_zvn,
               id_valid, id_opcode, id_ccc, id_imm9, id_pc_plus2, id_rs_data,
        input  flags, redirect_valid, redirect_pc, taken_count
    );

    modport slave (
        input  stall_in, ex_valid, ex_opcode, ex_zvn,
               id_valid, id_opcode, id_ccc, id_imm9, id_pc_plus2, id_rs_data,
        output flags, redirect_valid, redirect_pc, taken_count
    );

endinterface

// File: rtl/branch_cond_eval.sv
// Pure condition-code evaluator against a {Z,V,N} flag vector.
module branch_cond_eval
    import wisc_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] zvn,
    output logic       taken
);

    logic z, v, n;
    assign z = zvn[FLAG_Z];
    assign v = zvn[FLAG_V];
    assign n = zvn[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (ccc)
            CC_NE:   taken = !z;
            CC_EQ:   taken = z;
            CC_GT:   taken = !z && !n;
            CC_LT:   taken = n;
            CC_GTE:  taken = z || (!z && !n);
            CC_LTE:  taken = n || z;
            CC_OV:   taken = v;
            CC_UNC:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural ZVN flag register, B/BR resolution with EX->ID flag bypass,
// one-cycle registered PC redirect with wrong-path squash, taken counter.
module flag_branch_unit
    import wisc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    flag_branch_unit_if.slave bus
);

    logic [2:0]       flags_q, next_flags;
    logic             wr_z, wr_vn;
    logic             is_branch, cond_true, take;
    logic [15:0]      target;
    logic [15:0]      redirect_pc_q;
    logic [CNT_W-1:0] cnt_q;
    br_state_t        state_q, state_d;

    assign wr_z  = bus.ex_valid && !bus.stall_in && !bus.ex_opcode[3] &&
                   (bus.ex_opcode[1:0] != 2'b11);
    assign wr_vn = bus.ex_valid && !bus.stall_in && (bus.ex_opcode[3:1] == 3'b000);

    always_comb begin
        next_flags = flags_q;
        if (wr_z)
            next_flags[FLAG_Z] = bus.ex_zvn[FLAG_Z];
        if (wr_vn) begin
            next_flags[FLAG_V] = bus.ex_zvn[FLAG_V];
            next_flags[FLAG_N] = bus.ex_zvn[FLAG_N];
        end
    end

    // Evaluated on the bypassed flags so a flag setter right ahead needs no stall.
    branch_cond_eval u_cond (
        .ccc   (bus.id_ccc),
        .zvn   (next_flags),
        .taken (cond_true)
    );

    assign is_branch = (bus.id_opcode == OP_B) || (bus.id_opcode == OP_BR);
    assign target    = (bus.id_opcode == OP_BR) ? bus.id_rs_data
                                                : b_target(bus.id_pc_plus2, bus.id_imm9);
    // Only IDLE can take: in REDIRECT the ID instruction is wrong-path.
    assign take      = (state_q == ST_IDLE) && bus.id_valid && !bus.stall_in &&
                       is_branch && cond_true;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (take) state_d = ST_REDIRECT;
            ST_REDIRECT: if (!bus.stall_in) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q       <= 3'b000;
            state_q       <= ST_IDLE;
            redirect_pc_q <= 16'h0000;
            cnt_q         <= '0;
        end else begin
            flags_q <= next_flags;
            state_q <= state_d;
            if (take) begin
                redirect_pc_q <= target;
                if (cnt_q != {CNT_W{1'b1}})
                    cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.flags          = flags_q;
    assign bus.redirect_valid = (state_q == ST_REDIRECT);
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.taken_count    = cnt_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed, table-driven bench for flag_branch_unit plus hand sequences for
// reset mid-redirect and counter saturation (narrow-counter instance).
module tb_flag_branch_unit;
    import wisc_pkg::*;

    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_RED = 4'b0011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    flag_branch_unit_if #(.CNT_W(16)) bus ();
    flag_branch_unit_if #(.CNT_W(3))  sbus ();

    flag_branch_unit #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    flag_branch_unit #(.CNT_W(3)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus.slave)
    );

    typedef struct {
        logic        stall;
        logic        exv;
        logic [3:0]  exop;
        logic [2:0]  zvn;
        logic        idv;
        logic [3:0]  idop;
        logic [2:0]  ccc;
        logic [8:0]  imm;
        logic [15:0] pc;
        logic [15:0] rs;
        logic [2:0]  e_flags;
        logic        e_rv;
        logic [15:0] e_pc;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int row, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.stall_in    = v.stall;
        bus.ex_valid    = v.exv;
        bus.ex_opcode   = v.exop;
        bus.ex_zvn      = v.zvn;
        bus.id_valid    = v.idv;
        bus.id_opcode   = v.idop;
        bus.id_ccc      = v.ccc;
        bus.id_imm9     = v.imm;
        bus.id_pc_plus2 = v.pc;
        bus.id_rs_data  = v.rs;
    endtask

    task automatic add(input logic st, input logic ev, input logic [3:0] eo,
                       input logic [2:0] z, input logic iv, input logic [3:0] io,
                       input logic [2:0] c, input logic [8:0] im, input logic [15:0] p,
                       input logic [15:0] r, input logic [2:0] ef, input logic erv,
                       input logic [15:0] epc, input logic [15:0] ecnt);
        vec_t v;
        v = '{st, ev, eo, z, iv, io, c, im, p, r, ef, erv, epc, ecnt};
        vecs.push_back(v);
    endtask

    initial begin
        vec_t idle;
        idle = '{1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 4'h0, 3'b000, 9'h000, 16'h0, 16'h0,
                 3'b000, 1'b0, 16'h0, 16'h0};
        drive(idle);
        sbus.stall_in = 1'b0; sbus.ex_valid = 1'b0; sbus.ex_opcode = 4'h0;
        sbus.ex_zvn = 3'b000; sbus.id_valid = 1'b0; sbus.id_opcode = 4'h0;
        sbus.id_ccc = 3'b000; sbus.id_imm9 = 9'h0; sbus.id_pc_plus2 = 16'h0;
        sbus.id_rs_data = 16'h0;

        //  st ev  exop    zvn     iv idop   ccc     imm     pc       rs        flags  rv  rpc      cnt
        add(0, 1, OP_SUB, 3'b101, 0, 4'h0,  3'b000, 9'h000, 16'h0000, 16'h0000, 3'b101, 0, 16'h0000, 16'd0);
        add(0, 1, OP_XOR, 3'b010, 0, 4'h0,  3'b000, 9'h000, 16'h0000, 16'h0000, 3'b001, 0, 16'h0000, 16'd0);
        add(0, 1, OP_RED, 3'b111, 0, 4'h0,  3'b000, 9'h000, 16'h0000, 16'h0000, 3'b001, 0, 16'h0000, 16'd0);
        add(0, 1, OP_SUB, 3'b100, 1, OP_B,  CC_EQ,  9'h005, 16'h0010, 16'h0000, 3'b100, 1, 16'h001A, 16'd1);
        add(0, 0, 4'h0,   3'b000, 0, 4'h0,  3'b000, 9'h000, 16'h0000, 16'h0000, 3'b100, 0, 16'h001A, 16'd1);
        add(0, 0, 4'h0,   3'b000, 1, OP_B,  CC_UNC, 9'h1FC, 16'h0002, 16'h0000, 3'b100, 1, 16'hFFFA, 16'd2);
        add(0, 0, 4'h0,   3'b000, 0, 4'h0,  3'b000, 9'h000, 16'h0000, 16'h0000, 3'b100, 0, 16'hFFFA, 16'd2);
        add(0, 0, 4'h0,   3'b000, 1, OP_BR, CC_UNC, 9'h000, 16'h0000, 16'h1234, 3'b100, 1, 16'h1234, 16'd3);
        add(0, 0, 4'h0,   3'b000, 1, OP_B,  CC_UNC, 9'h010, 16'h0100, 16'h0000, 3'b100, 0, 16'h1234, 16'd3);
        add(0, 0, 4'h0,   3'b000, 0, 4'h0,  3'b000, 9'h000, 16'h0000, 16'h0000, 3'b100, 0, 16'h1234, 16'd3);
        add(0, 0, 4'h0,   3'b000, 1, OP_B,  CC_NE,  9'h001, 16'h0040, 16'h0000, 3'b100, 0, 16'h1234, 16'd3);
        add(0, 0, 4'h0,   3'b000, 0, OP_B,  CC_UNC, 9'h001, 16'h0040, 16'h0000, 3'b100, 0, 16'h1234, 16'd3);
        add(0, 1, OP_ADD, 3'b011, 1, OP_B,  CC_LT,  9'h0FF, 16'h0200, 16'h0000, 3'b011, 1, 16'h03FE, 16'd4);
        add(0, 1, OP_ADD, 3'b000, 1, OP_B,  CC_UNC, 9'h000, 16'h0000, 16'h0000, 3'b000, 0, 16'h03FE, 16'd4);
        add(0, 0, OP_SUB, 3'b111, 1, OP_B,  CC_OV,  9'h000, 16'h0000, 16'h0000, 3'b000, 0, 16'h03FE, 16'd4);
        add(1, 1, OP_SUB, 3'b111, 1, OP_B,  CC_UNC, 9'h000, 16'h0000, 16'h0000, 3'b000, 0, 16'h03FE, 16'd4);
        add(0, 0, 4'h0,   3'b000, 1, OP_B,  CC_GT,  9'h100, 16'h1000, 16'h0000, 3'b000, 1, 16'h0E00, 16'd5);
        add(1, 1, OP_ADD, 3'b111, 1, OP_B,  CC_UNC, 9'h000, 16'h0000, 16'h0000, 3'b000, 1, 16'h0E00, 16'd5);
        add(1, 0, 4'h0,   3'b000, 0, 4'h0,  3'b000, 9'h000, 16'h0000, 16'h0000, 3'b000, 1, 16'h0E00, 16'd5);
        add(1, 0, 4'h0,   3'b000, 0, 4'h0,  3'b000, 9'h000, 16'h0000, 16'h0000, 3'b000, 1, 16'h0E00, 16'd5);
        add(0, 0, 4'h0,   3'b000, 0, 4'h0,  3'b000, 9'h000, 16'h0000, 16'h0000, 3'b000, 0, 16'h0E00, 16'd5);
        add(0, 1, OP_SUB, 3'b000, 1, OP_BR, CC_LTE, 9'h000, 16'h0000, 16'hBEEF, 3'b000, 0, 16'h0E00, 16'd5);
        add(0, 0, 4'h0,   3'b000, 1, OP_BR, CC_GTE, 9'h000, 16'h0000, 16'hBEEF, 3'b000, 1, 16'hBEEF, 16'd6);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_flags", -1, 16'(bus.flags), 16'h0);
        chk("reset_rv",    -1, 16'(bus.redirect_valid), 16'h0);
        chk("reset_pc",    -1, bus.redirect_pc, 16'h0);
        chk("reset_cnt",   -1, bus.taken_count, 16'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            chk("flags",          i, 16'(bus.flags), 16'(vecs[i].e_flags));
            chk("redirect_valid", i, 16'(bus.redirect_valid), 16'(vecs[i].e_rv));
            chk("redirect_pc",    i, bus.redirect_pc, vecs[i].e_pc);
            chk("taken_count",    i, bus.taken_count, vecs[i].e_cnt);
        end

        // Reset while in REDIRECT, with a taken branch and flag writer present
        rst_n = 1'b0;
        bus.ex_valid = 1'b1; bus.ex_opcode = OP_SUB; bus.ex_zvn = 3'b111;
        bus.id_valid = 1'b1; bus.id_opcode = OP_B; bus.id_ccc = CC_UNC;
        bus.id_imm9 = 9'h001; bus.id_pc_plus2 = 16'h0040;
        @(negedge clk);
        chk("rst_mid_flags", 100, 16'(bus.flags), 16'h0);
        chk("rst_mid_rv",    100, 16'(bus.redirect_valid), 16'h0);
        chk("rst_mid_pc",    100, bus.redirect_pc, 16'h0);
        chk("rst_mid_cnt",   100, bus.taken_count, 16'h0);
        rst_n = 1'b1;
        drive(idle);
        @(negedge clk);
        chk("post_rst_rv",  101, 16'(bus.redirect_valid), 16'h0);
        chk("post_rst_cnt", 101, bus.taken_count, 16'h0);

        // Saturation on a 3-bit counter: 7 takes fill it, the 8th still redirects
        sbus.id_valid = 1'b1; sbus.id_opcode = OP_B; sbus.id_ccc = CC_UNC;
        sbus.id_imm9 = 9'h001; sbus.id_pc_plus2 = 16'h0000;
        repeat (13) @(negedge clk);
        chk("sat_cnt_fill", 200, 16'(sbus.taken_count), 16'd7);
        chk("sat_rv_fill",  200, 16'(sbus.redirect_valid), 16'h1);
        repeat (2) @(negedge clk);
        chk("sat_cnt_hold", 201, 16'(sbus.taken_count), 16'd7);
        chk("sat_rv_hold",  201, 16'(sbus.redirect_valid), 16'h1);
        chk("sat_pc",       201, sbus.redirect_pc, 16'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
